// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package imem_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } imem_state_e;

   localparam int IMEM_NOP_DEFAULT = 0;

   // Pointer width for a memory of 'depth' words; never narrower than 1 bit.
   function automatic int ptr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one write port, one synchronous read port, no reset.
module imem_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256,
   parameter int AW     = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/instruction_mem_loadable.sv
// Instruction memory with power-up clear sweep and streaming program loader.
//
//   state | meaning
//   CLEAR | sweeping NOP_WORD into every word, fetches stalled
//   LOAD  | accepting program words at ptr, fetches stalled
//   RUN   | serving fetches, waiting for load_start
module instruction_mem_loadable
   import imem_pkg::*;
#(
   parameter int                 DATA_W   = 16,
   parameter int                 ADDR_W   = 16,
   parameter int                 DEPTH    = 256,
   parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(IMEM_NOP_DEFAULT)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load_start,
   input  logic                           load_valid,
   input  logic                           load_last,
   input  logic [DATA_W-1:0]              load_data,
   output logic                           load_ready,
   output logic [ptr_width(DEPTH):0]      load_count,
   input  logic                           fetch_req,
   input  logic [ADDR_W-1:0]              pc_out,
   output logic [DATA_W-1:0]              instr_out,
   output logic                           instr_valid,
   output logic                           fetch_stall,
   output logic                           addr_fault
);

   localparam int                PTR_W    = ptr_width(DEPTH);
   localparam int                CNT_W    = PTR_W + 1;
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

   imem_state_e       state;
   logic [PTR_W-1:0]  ptr;
   logic              nop_sel;
   logic              in_range;
   logic              fetch_accept;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_re;
   logic [DATA_W-1:0] ram_rdata;

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   assign in_range     = {1'b0, pc_out} < DEPTH_A;
   assign fetch_accept = fetch_req && (state == RUN) && !load_start;
   assign fetch_stall  = fetch_req && !((state == RUN) && !load_start);

   assign ram_we    = (state == CLEAR) || ((state == LOAD) && load_valid && !load_start);
   assign ram_wdata = (state == CLEAR) ? NOP_WORD : load_data;
   assign ram_re    = fetch_accept && in_range;

   // RAM output has no reset, so faulting fetches and reset select NOP_WORD instead.
   assign instr_out = nop_sel ? NOP_WORD : ram_rdata;

   imem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ptr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (pc_out[PTR_W-1:0]),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= CLEAR;
         ptr         <= '0;
         load_count  <= '0;
         load_ready  <= 1'b0;
         instr_valid <= 1'b0;
         addr_fault  <= 1'b0;
         nop_sel     <= 1'b1;
      end else begin
         instr_valid <= fetch_accept;
         addr_fault  <= fetch_accept && !in_range;
         if (fetch_accept) nop_sel <= !in_range;

         case (state)
            CLEAR: begin
               if (ptr == LAST_PTR) begin
                  state <= RUN;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + PTR_W'(1);
               end
            end
            RUN: begin
               if (load_start) begin
                  state      <= LOAD;
                  ptr        <= '0;
                  load_count <= '0;
                  load_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (load_start) begin
                  ptr        <= '0;
                  load_count <= '0;
               end else if (load_valid) begin
                  load_count <= load_count + CNT_W'(1);
                  // Pointer stops at the top word rather than wrapping onto word 0.
                  if (load_last || (ptr == LAST_PTR)) begin
                     state      <= RUN;
                     load_ready <= 1'b0;
                  end else begin
                     ptr <= ptr + PTR_W'(1);
                  end
               end
            end
            default: begin
               state      <= CLEAR;
               ptr        <= '0;
               load_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_mem_loadable.sv
// Directed bench for instruction_mem_loadable: clear sweep, loads, fetches, faults, reset abort.
module tb_instruction_mem_loadable;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 256;

   logic              clk = 1'b0;
   logic              rst;
   logic              load_start, load_valid, load_last;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic [8:0]        load_count;
   logic              fetch_req;
   logic [ADDR_W-1:0] pc_out;
   logic [DATA_W-1:0] instr_out;
   logic              instr_valid, fetch_stall, addr_fault;

   int checks   = 0;
   int failures = 0;

   instruction_mem_loadable #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .NOP_WORD (16'h0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_last   (load_last),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_count  (load_count),
      .fetch_req   (fetch_req),
      .pc_out      (pc_out),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .fetch_stall (fetch_stall),
      .addr_fault  (addr_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] pc, input logic [15:0] exp, input logic exp_fault, input string tag);
      fetch_req = 1'b1;
      pc_out    = pc;
      step();
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_instr"}, {16'd0, instr_out}, {16'd0, exp});
      chk({tag, "_fault"}, {31'd0, addr_fault}, {31'd0, exp_fault});
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   bit found;

   initial begin
      rst        = 1'b1;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_data  = '0;
      fetch_req  = 1'b0;
      pc_out     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", {16'd0, instr_out}, 32'h0);
      chk("rst_fault", {31'd0, addr_fault}, 32'd0);
      chk("rst_ready", {31'd0, load_ready}, 32'd0);
      chk("rst_count", {23'd0, load_count}, 32'd0);

      // Clear sweep: DEPTH stalled cycles with a pending fetch of PC 5.
      rst       = 1'b0;
      fetch_req = 1'b1;
      pc_out    = 16'd5;
      #1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("clr_stall", {31'd0, fetch_stall}, 32'd1);
         chk("clr_valid", {31'd0, instr_valid}, 32'd0);
         step();
      end
      chk("run_nostall", {31'd0, fetch_stall}, 32'd0);
      step();
      chk("clr_first_valid", {31'd0, instr_valid}, 32'd1);
      chk("clr_first_instr", {16'd0, instr_out}, 32'h0);
      chk("clr_first_fault", {31'd0, addr_fault}, 32'd0);

      // Short program; fetch in the load_start cycle must be stalled.
      pc_out     = 16'd0;
      load_start = 1'b1;
      #1;
      chk("start_stall", {31'd0, fetch_stall}, 32'd1);
      step();
      load_start = 1'b0;
      fetch_req  = 1'b0;
      chk("start_novalid", {31'd0, instr_valid}, 32'd0);
      chk("start_ready", {31'd0, load_ready}, 32'd1);
      chk("start_count", {23'd0, load_count}, 32'd0);
      load_valid = 1'b1;
      load_data = 16'h9205; step();
      load_data = 16'h923B; step();
      load_data = 16'h928F; load_last = 1'b1; step();
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("p1_count", {23'd0, load_count}, 32'd3);
      chk("p1_ready", {31'd0, load_ready}, 32'd0);
      fetch(16'd0, 16'h9205, 1'b0, "p1_pc0");
      fetch(16'd1, 16'h923B, 1'b0, "p1_pc1");
      fetch(16'd2, 16'h928F, 1'b0, "p1_pc2");
      fetch_req = 1'b0;
      step();
      chk("idle_valid", {31'd0, instr_valid}, 32'd0);
      chk("idle_hold", {16'd0, instr_out}, 32'h928F);

      // Out-of-range fetches.
      fetch(16'd256, 16'h0000, 1'b1, "flt_256");
      fetch(16'hFFFF, 16'h0000, 1'b1, "flt_ffff");
      fetch(16'd2, 16'h928F, 1'b0, "flt_after");
      fetch_req = 1'b0;

      // Overlong load: pointer stops at the top word.
      pulse_start();
      load_valid = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         load_data = 16'hA000 + 16'(i);
         #1;
         chk("full_ready", {31'd0, load_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
         step();
      end
      load_valid = 1'b0;
      chk("full_count", {23'd0, load_count}, 32'd256);
      fetch(16'd255, 16'hA0FF, 1'b0, "full_pc255");
      fetch(16'd0, 16'hA000, 1'b0, "full_pc0");
      fetch_req = 1'b0;

      // Restart mid-load; word presented with load_start is dropped.
      pulse_start();
      load_valid = 1'b1;
      load_data = 16'h1111; step();
      load_data = 16'h2222; step();
      load_start = 1'b1;
      load_data  = 16'h3333;
      step();
      load_start = 1'b0;
      chk("rs_count0", {23'd0, load_count}, 32'd0);
      load_data = 16'hC041;
      load_last = 1'b1;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("rs_count", {23'd0, load_count}, 32'd1);
      fetch(16'd0, 16'hC041, 1'b0, "rs_pc0");
      fetch(16'd1, 16'h2222, 1'b0, "rs_pc1");
      fetch(16'd2, 16'hA002, 1'b0, "rs_pc2");
      fetch_req = 1'b0;

      // Reset in the middle of a load.
      pulse_start();
      load_valid = 1'b1;
      load_data  = 16'h5555;
      step();
      load_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_instr", {16'd0, instr_out}, 32'h0);
      chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
      chk("mrst_fault", {31'd0, addr_fault}, 32'd0);
      chk("mrst_ready", {31'd0, load_ready}, 32'd0);
      chk("mrst_count", {23'd0, load_count}, 32'd0);
      step();
      rst       = 1'b0;
      fetch_req = 1'b1;
      pc_out    = 16'd0;
      found     = 1'b0;
      for (int i = 0; i < DEPTH + 20; i++) begin
         step();
         if (instr_valid) begin
            found = 1'b1;
            break;
         end
      end
      chk("mrst_fetch_seen", {31'd0, found}, 32'd1);
      chk("mrst_pc0", {16'd0, instr_out}, 32'h0);
      fetch_req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
